// File: rtl/cpu_data_mem.sv
// cpu_data_mem: word-organised data/stack memory with byte-lane writes and fixed-latency ready/error pulses
module cpu_data_mem #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wrdata_i,
  input  logic [3:0]  mem_byte_en_i,
  input  logic        mem_wr_en_i,
  input  logic        mem_rd_en_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rddata_o,
  output logic        mem_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, hold_q, hold_d, rddata_q;
  logic [3:0]        be_q, be_d;
  logic              wr_q, wr_d, oor_q, oor_d, both_q, both_d;
  logic              ready_q, err_q;
  logic              req, accept, in_range, go_resp, commit;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  assign req      = mem_rd_en_i | mem_wr_en_i;
  assign accept   = req && state_q == IDLE;
  assign in_range = (mem_addr_i >> ADDR_W) == 32'd0;

  // With zero wait states the accept edge is also the commit edge, so the
  // response path works from next-state values rather than the latched ones.
  assign addr_d  = accept ? mem_addr_i[ADDR_W-1:0] : addr_q;
  assign wdata_d = accept ? mem_wrdata_i : wdata_q;
  assign be_d    = accept ? mem_byte_en_i : be_q;
  assign wr_d    = accept ? mem_wr_en_i : wr_q;
  assign oor_d   = accept ? !in_range : oor_q;
  assign both_d  = accept ? (mem_rd_en_i & mem_wr_en_i) : both_q;
  assign hold_d  = accept ? (in_range ? mem[mem_addr_i[ADDR_W-1:0]] : 32'h0) : hold_q;
  assign go_resp = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd1);
  assign commit  = go_resp && wr_d && !oor_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      wr_q     <= 1'b0;
      oor_q    <= 1'b0;
      both_q   <= 1'b0;
      hold_q   <= 32'h0;
      rddata_q <= 32'h0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= go_resp ? RESP : accept ? WAIT : state_q == RESP ? IDLE : state_q;
      cnt_q    <= accept ? 4'(WAIT_CYCLES) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      oor_q    <= oor_d;
      both_q   <= both_d;
      hold_q   <= hold_d;
      ready_q  <= go_resp;
      err_q    <= (go_resp && (oor_d || both_d)) || (req && state_q != IDLE);
      if (go_resp && !wr_d) rddata_q <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit)
      for (int n = 0; n < 4; n++)
        if (be_d[n]) mem[addr_d][8*n +: 8] <= wdata_d[8*n +: 8];
  end

  assign mem_ready_o  = ready_q;
  assign mem_err_o    = err_q;
  assign mem_rddata_o = rddata_q;
endmodule

// File: tb/tb_cpu_data_mem.sv
// tb_cpu_data_mem: directed checks of a zero-wait and a three-wait-state instance
module tb_cpu_data_mem;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] a0_addr = 0, a0_wd = 0, a3_addr = 0, a3_wd = 0;
  logic [3:0]  a0_be = 0, a3_be = 0;
  logic        a0_wr = 0, a0_rd = 0, a3_wr = 0, a3_rd = 0;
  logic        r0, e0, r3, e3;
  logic [31:0] d0, d3;
  int          vectors = 0, miscompares = 0;
  logic        seen;

  always #5 clk = ~clk;

  cpu_data_mem #(.ADDR_W(12), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .resetn(resetn), .mem_addr_i(a0_addr), .mem_wrdata_i(a0_wd),
    .mem_byte_en_i(a0_be), .mem_wr_en_i(a0_wr), .mem_rd_en_i(a0_rd),
    .mem_ready_o(r0), .mem_rddata_o(d0), .mem_err_o(e0));

  cpu_data_mem #(.ADDR_W(12), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .resetn(resetn), .mem_addr_i(a3_addr), .mem_wrdata_i(a3_wd),
    .mem_byte_en_i(a3_be), .mem_wr_en_i(a3_wr), .mem_rd_en_i(a3_rd),
    .mem_ready_o(r3), .mem_rddata_o(d3), .mem_err_o(e3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req0(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be);
    a0_rd = rd; a0_wr = wr; a0_addr = addr; a0_wd = wd; a0_be = be;
    tick();
    a0_rd = 0; a0_wr = 0;
  endtask

  task automatic set3(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be);
    a3_rd = rd; a3_wr = wr; a3_addr = addr; a3_wd = wd; a3_be = be;
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready0", {31'b0, r0}, 0);
    chk("rst_err0", {31'b0, e0}, 0);
    chk("rst_data0", d0, 0);
    chk("rst_ready3", {31'b0, r3}, 0);
    chk("rst_data3", d3, 0);
    resetn = 1'b1;
    tick();

    req0(0, 1, 5, 32'hCAFE_F00D, 4'hF);
    chk("wr5_ready", {31'b0, r0}, 1);
    chk("wr5_err", {31'b0, e0}, 0);
    chk("wr5_data_unchanged", d0, 0);
    tick();
    chk("wr5_ready_gone", {31'b0, r0}, 0);
    req0(1, 0, 5, 0, 4'h0);
    chk("rd5_ready", {31'b0, r0}, 1);
    chk("rd5_data", d0, 32'hCAFE_F00D);
    tick();

    req0(0, 1, 7, 32'h1122_3344, 4'hF); tick();
    req0(0, 1, 7, 32'hAABB_CCDD, 4'b0110); tick();
    req0(1, 0, 7, 0, 4'h0);
    chk("lanes_rd7", d0, 32'h11BB_CC44);
    tick();
    req0(0, 1, 7, 32'h5555_5555, 4'h0);
    chk("be0_ready", {31'b0, r0}, 1);
    tick();
    req0(1, 0, 7, 0, 4'h0);
    chk("be0_rd7", d0, 32'h11BB_CC44);
    tick();

    req0(0, 1, 0, 32'h1234_5678, 4'hF); tick();
    req0(1, 0, 32'h0000_1000, 0, 4'h0);
    chk("oor_rd_ready", {31'b0, r0}, 1);
    chk("oor_rd_err", {31'b0, e0}, 1);
    chk("oor_rd_data", d0, 0);
    tick();
    chk("oor_err_gone", {31'b0, e0}, 0);
    req0(0, 1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
    chk("oor_wr_err", {31'b0, e0}, 1);
    tick();
    req0(1, 0, 0, 0, 4'h0);
    chk("oor_wr_addr0", d0, 32'h1234_5678);
    chk("rd0_err", {31'b0, e0}, 0);
    tick();

    req0(1, 1, 3, 32'h5, 4'hF);
    chk("both_ready", {31'b0, r0}, 1);
    chk("both_err", {31'b0, e0}, 1);
    chk("both_data_held", d0, 32'h1234_5678);
    tick();
    chk("both_single_ready", {31'b0, r0}, 0);
    req0(1, 0, 3, 0, 4'h0);
    chk("both_rd3", d0, 32'h5);
    tick();

    set3(0, 1, 1, 32'hDEAD_BEEF, 4'hF);
    tick(); set3(0, 0, 0, 0, 0);
    chk("w3_c1", {31'b0, r3}, 0);
    tick(); chk("w3_c2", {31'b0, r3}, 0);
    tick(); chk("w3_c3", {31'b0, r3}, 0);
    tick(); chk("w3_c4", {31'b0, r3}, 1);
    tick(); chk("w3_c5", {31'b0, r3}, 0);

    set3(1, 0, 1, 0, 0);
    tick(); set3(0, 0, 0, 0, 0);
    chk("r3_c1", {31'b0, r3}, 0);
    tick(); set3(1, 0, 2, 0, 0);
    chk("r3_c2_err", {31'b0, e3}, 0);
    tick(); set3(0, 0, 0, 0, 0);
    chk("r3_c3_err", {31'b0, e3}, 1);
    chk("r3_c3_ready", {31'b0, r3}, 0);
    tick();
    chk("r3_c4_ready", {31'b0, r3}, 1);
    chk("r3_c4_err", {31'b0, e3}, 0);
    chk("r3_c4_data", d3, 32'hDEAD_BEEF);
    tick();
    chk("r3_c5_ready", {31'b0, r3}, 0);

    set3(0, 1, 9, 32'h0909_0909, 4'hF);
    tick(); set3(0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    set3(0, 1, 9, 32'h0000_0BAD, 4'hF);
    tick(); set3(0, 0, 0, 0, 0);
    tick();
    resetn = 1'b0;
    tick(); tick();
    chk("mid_rst_ready", {31'b0, r3}, 0);
    chk("mid_rst_err", {31'b0, e3}, 0);
    chk("mid_rst_data", d3, 0);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | r3 | e3;
    end
    chk("mid_rst_no_ready", {31'b0, seen}, 0);
    set3(1, 0, 9, 0, 0);
    tick(); set3(0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("mid_rst_rd9_ready", {31'b0, r3}, 1);
    chk("mid_rst_rd9", d3, 32'h0909_0909);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_data_mem.md
# cpu_data_mem

Word-organised data/stack memory that serves the execute stage's memory request port (loads, stores, CALL return-address pushes, RET pops). It accepts single-cycle read/write request pulses, applies per-byte write enables, and returns a one-cycle `mem_ready_o` pulse with read data after a fixed, parameterised latency. It sits between the CPU execute stage and on-chip block RAM; contents are not initialised by reset.

## Interface
- `ADDR_W`, 12: word-address width; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 0: extra response wait states, 0–15.

- `clk` input 1: single clock, all logic on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `mem_addr_i` input 32: word address; bits [31:ADDR_W] must be zero.
- `mem_wrdata_i` input 32: write data.
- `mem_byte_en_i` input 4: byte-lane write enables, bit n = bits [8n+7:8n]; ignored on reads.
- `mem_wr_en_i` input 1: one-cycle write request pulse.
- `mem_rd_en_i` input 1: one-cycle read request pulse.
- `mem_ready_o` output 1: one-cycle completion pulse, reads and writes.
- `mem_rddata_o` output 32: read data; valid with `mem_ready_o`, held until the next read completes.
- `mem_err_o` output 1: one-cycle error pulse.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on `mem_rd_en_i | mem_wr_en_i`, latch address, write data, byte enables, type and range check. Go to WAIT if WAIT_CYCLES > 0, else RESP. Load wait counter with WAIT_CYCLES.
- WAIT: decrement counter each cycle; on reaching 1, go to RESP.
- RESP: `mem_ready_o` = 1 for exactly this cycle. Go to IDLE next cycle.
- Read: array read at the accept edge into a holding register. That register is copied to `mem_rddata_o` on the edge entering RESP. Always returns the full 32-bit word.
- Write: only lanes with `mem_byte_en_i[n]` = 1 are updated; other lanes are preserved. `mem_byte_en_i` = 0000 completes with ready but changes nothing. The array write commits on the edge entering RESP. `mem_rddata_o` is unchanged by writes.
- Out of range (`mem_addr_i[31:ADDR_W]` != 0):
  - Read: returns 32'h0000_0000.
  - Write: dropped.
  - In both cases `mem_err_o` pulses in the RESP cycle, together with `mem_ready_o`.
- Simultaneous `mem_rd_en_i` and `mem_wr_en_i` in IDLE: the write is performed, the read is discarded, and `mem_err_o` pulses with `mem_ready_o`.
- Request while not IDLE (WAIT or RESP): the request is ignored, with no ready for it. `mem_err_o` pulses in the following cycle. The in-flight transaction is unaffected.

## Timing
- Request sampled at edge E. `mem_ready_o` is high in the cycle after edge E+WAIT_CYCLES, i.e. latency = WAIT_CYCLES+1 cycles. WAIT_CYCLES=0 gives ready in the cycle right after the request.
- Minimum request spacing = WAIT_CYCLES+2 cycles. The next request may be sampled in the cycle after RESP.
- Read-after-write to the same address, spaced at the minimum, returns the new data.
- Reset values: `mem_ready_o`=0, `mem_err_o`=0, `mem_rddata_o`=32'h0, FSM=IDLE, counter=0. Array contents are not reset.
- Reset asserted mid-transaction: the transaction is abandoned, a pending write is not committed, and no ready is issued after release.

## Test plan
- WAIT_CYCLES=0: write 32'hCAFE_F00D, byte_en F, addr 5. Then, 2 cycles after the request, read addr 5 -> ready 1 cycle after each request; read returns 32'hCAFE_F00D.
- Byte lanes: addr 7 holds 32'h1122_3344; write 32'hAABB_CCDD with byte_en 0110 -> a subsequent read returns 32'h11BB_CC44. A write with byte_en 0000 leaves it unchanged, with ready still pulsing.
- WAIT_CYCLES=3: read request at cycle 0 -> `mem_ready_o` high only in cycle 4. A read pulse at cycle 2 -> ignored, `mem_err_o` in cycle 3, with cycle-4 data correct.
- Out of range, ADDR_W=12: read addr 32'h0000_1000 -> ready with data 0 and `mem_err_o` high the same cycle. Write 32'hFFFF_FFFF to 32'h0000_1000 -> addr 0 is not modified.
- Simultaneous rd and wr to addr 3 with data 32'h5 -> a single ready with `mem_err_o`; addr 3 becomes 32'h5; `mem_rddata_o` unchanged.
- WAIT_CYCLES=3: assert `resetn`=0 during WAIT of a write to addr 9 -> after release, all outputs are 0, no ready appears, and addr 9 retains its old value.
